// File: rtl/sym_pkg.sv
// Shared types for the 2-bit symbol packer.
//   sym_t        : one 2-bit input symbol
//   word_t       : packed 8-bit output word (four symbols, LSB-first)
//   cnt_t        : number of valid symbols in a word, 1..4
//   pack_state_t : assembly state (EMPTY / FILL)
//   fifo_entry_t : one queued {word, count} pair
package sym_pkg;

    localparam int SYMS = 4;

    typedef bit [1:0] sym_t;
    typedef bit [7:0] word_t;
    typedef bit [2:0] cnt_t;

    typedef enum bit {EMPTY, FILL} pack_state_t;

    typedef struct packed {
        word_t word;
        cnt_t  count;
    } fifo_entry_t;

endpackage

// File: rtl/sym_packer_if.sv
// Handshake bundle for sym_packer.
//   in_valid/in_ready/in_sym/in_last : symbol input handshake
//   out_valid/out_ready/out_word/out_count : packed word output handshake
// modport slave  : the packer side
// modport master : the producer/consumer side driving the packer
interface sym_packer_if;
    import sym_pkg::*;

    logic  in_valid;
    logic  in_ready;
    sym_t  in_sym;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    word_t out_word;
    cnt_t  out_count;

    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_word, out_count
    );

    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_count
    );

endinterface

// File: rtl/sym_fifo.sv
// Small synchronous FIFO of {word, count} entries.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry (ignored when full)
//   pop/dout : remove the head entry (ignored when empty); dout is the head
//   full, empty : occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable.
module sym_fifo
    import sym_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sym_packer.sv
// Packs 2-bit symbols, LSB-first, into 8-bit words and queues them.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sym_packer_if.slave handshake bundle
//     in_valid/in_ready/in_sym/in_last : symbol input; in_last closes a word early
//     out_valid/out_ready/out_word/out_count : queued word output; zeros when empty
module sym_packer
    import sym_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    sym_packer_if.slave  bus
);

    pack_state_t state_q;
    pack_state_t state_d;
    word_t       acc;
    word_t       acc_next;
    logic [1:0]  idx;
    logic        accept;
    logic        complete;
    fifo_entry_t fifo_din;
    fifo_entry_t fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign complete     = accept && ((idx == 2'd3) || bus.in_last);

    // Bits above the current index are always zero in acc, so the pushed
    // word needs no extra masking.
    always_comb begin
        acc_next = acc;
        acc_next[{idx, 1'b0} +: 2] = bus.in_sym;
    end

    assign fifo_din.word  = acc_next;
    assign fifo_din.count = {1'b0, idx} + 3'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept && !bus.in_last) state_d = FILL;
            FILL:  if (complete)              state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc     <= '0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (complete) begin
                acc <= '0;
                idx <= '0;
            end else if (accept) begin
                acc <= acc_next;
                idx <= idx + 2'd1;
            end
        end
    end

    sym_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (complete),
        .din   (fifo_din),
        .pop   (bus.out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_word  = fifo_empty ? '0 : fifo_dout.word;
    assign bus.out_count = fifo_empty ? '0 : fifo_dout.count;

endmodule

// File: tb/tb_sym_packer.sv
// Directed self-checking bench for sym_packer (DEPTH = 4).
module tb_sym_packer;
    import sym_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sym_packer_if bus ();

    sym_packer #(
        .DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic last);
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] w, input logic [2:0] c);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".word"},  32'(bus.out_word),  32'(w));
        check({tag, ".count"}, 32'(bus.out_count), 32'(c));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check_out("rst", 1'b0, 8'h00, 3'd0);

        // Full word 1,2,3,0 with consumer ready
        bus.out_ready = 1'b1;
        send(2'd1, 1'b0);
        check("full.v1", 32'(bus.out_valid), 32'd0);
        send(2'd2, 1'b0);
        send(2'd3, 1'b0);
        check("full.v3", 32'(bus.out_valid), 32'd0);
        send(2'd0, 1'b0);
        check_out("full", 1'b1, 8'h39, 3'd4);
        tick();
        check("full.popped", 32'(bus.out_valid), 32'd0);

        // Partial flush 3, 2+last
        send(2'd3, 1'b0);
        send(2'd2, 1'b1);
        check_out("part", 1'b1, 8'h0B, 3'd2);
        tick();
        check("part.popped", 32'(bus.out_valid), 32'd0);
        send(2'd1, 1'b1);
        check_out("part.restart", 1'b1, 8'h01, 3'd1);
        tick();

        // Backpressure: 16 symbols into a 4-deep FIFO
        bus.out_ready = 1'b0;
        begin
            logic [1:0] syms [16];
            syms = '{2'd0, 2'd1, 2'd2, 2'd3,
                     2'd3, 2'd2, 2'd1, 2'd0,
                     2'd1, 2'd1, 2'd1, 2'd1,
                     2'd2, 2'd2, 2'd2, 2'd2};
            for (int i = 0; i < 16; i++) begin
                if (i == 15) check("bp.ready_before_last", 32'(bus.in_ready), 32'd1);
                send(syms[i], 1'b0);
            end
        end
        check("bp.full", 32'(bus.in_ready), 32'd0);
        check_out("bp.head", 1'b1, 8'hE4, 3'd4);
        // Offered while full: must be dropped.
        send(2'd3, 1'b0);
        check_out("bp.hold", 1'b1, 8'hE4, 3'd4);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp.ready_after_pop", 32'(bus.in_ready), 32'd1);
        check_out("bp.w1", 1'b1, 8'h1B, 3'd4);
        bus.out_ready = 1'b1;
        tick();
        check_out("bp.w2", 1'b1, 8'h55, 3'd4);
        tick();
        check_out("bp.w3", 1'b1, 8'hAA, 3'd4);
        tick();
        check_out("bp.drained", 1'b0, 8'h00, 3'd0);

        // Simultaneous push and pop with one queued entry
        bus.out_ready = 1'b0;
        send(2'd2, 1'b0);
        send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        check_out("pp.before", 1'b1, 8'h02, 3'd4);
        bus.out_ready = 1'b1;
        send(2'd1, 1'b0);
        check_out("pp.after", 1'b1, 8'h55, 3'd4);
        tick();
        check("pp.drained", 32'(bus.out_valid), 32'd0);

        // Mid-word reset discards the partial word
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr.in_ready", 32'(bus.in_ready), 32'd1);
        check_out("mr.rst", 1'b0, 8'h00, 3'd0);
        send(2'd1, 1'b0);
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        send(2'd0, 1'b0);
        check_out("mr.word", 1'b1, 8'h11, 3'd4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
